// File: rtl/mul_sched_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
package mul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single requester still needs a 1-bit ID, so the width never drops to 0.
  function automatic int id_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// Iterative shift-add multiplier: one multiplier bit per step, finished when b runs out.
module mul_shift_add_core #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           step_en,
  output logic           finished,
  output logic [2*N-1:0] acc
);

  logic [2*N-1:0] a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic [2*N-1:0] acc_q, acc_d;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    if (load) begin
      a_d   = {{N{1'b0}}, a};
      b_d   = b;
      acc_d = '0;
    end else if (step_en && (b_q != '0)) begin
      if (b_q[0]) acc_d = acc_q + a_q;
      b_d = b_q >> 1;
      a_d = a_q << 1;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
    end
  end

  assign finished = (b_q == '0);
  assign acc      = acc_q;

endmodule

// File: rtl/mul_rr_scheduler.sv
// Round-robin arbiter that time-shares one shift-add multiplier between R requesters.
module mul_rr_scheduler
  import mul_sched_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int R  = 4,
  localparam int IW = id_width(R)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] op_a,
  input  logic [R*N-1:0] op_b,
  output logic [R-1:0]   grant,
  output logic [R-1:0]   done,
  output logic [IW-1:0]  done_id,
  output logic [2*N-1:0] result,
  output logic           busy
);

  state_e         state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [IW-1:0]  cur_id_q, cur_id_d;
  logic [R-1:0]   grant_q, grant_d;
  logic [R-1:0]   done_q, done_d;
  logic [IW-1:0]  done_id_q, done_id_d;
  logic [2*N-1:0] result_q, result_d;

  logic [IW-1:0]  win;
  logic [N-1:0]   sel_a, sel_b;
  logic           core_load, core_step, core_finished;
  logic [2*N-1:0] core_acc;

  // First requester after the pointer, wrapping modulo R.
  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    win   = ptr_q;
    for (int k = 1; k <= R; k++) begin
      idx = (int'(ptr_q) + k) % R;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
    sel_a = op_a[int'(win)*N +: N];
    sel_b = op_b[int'(win)*N +: N];
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cur_id_d  = cur_id_q;
    grant_d   = '0;
    done_d    = '0;
    done_id_d = done_id_q;
    result_d  = result_q;
    core_load = 1'b0;
    core_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req != '0) begin
          grant_d[win] = 1'b1;
          core_load    = 1'b1;
          cur_id_d     = win;
          ptr_d        = win;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (core_finished) begin
          result_d         = core_acc;
          done_d[cur_id_q] = 1'b1;
          done_id_d        = cur_id_q;
          state_d          = DONE;
        end else begin
          core_step = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(R - 1);
      cur_id_q  <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      done_id_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cur_id_q  <= cur_id_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      result_q  <= result_d;
    end
  end

  mul_shift_add_core #(.N(N)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .a        (sel_a),
    .b        (sel_b),
    .step_en  (core_step),
    .finished (core_finished),
    .acc      (core_acc)
  );

  assign grant   = grant_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign result  = result_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Scoreboard bench for mul_rr_scheduler: a cycle-level reference model predicts grants and products.
module tb_mul_rr_scheduler;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [R-1:0]   req = '0;
  logic [R*N-1:0] op_a = '0;
  logic [R*N-1:0] op_b = '0;
  logic [R-1:0]   grant;
  logic [R-1:0]   done;
  logic [IW-1:0]  done_id;
  logic [2*N-1:0] result;
  logic           busy;

  mul_rr_scheduler #(.N(N), .R(R)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .op_a    (op_a),
    .op_b    (op_b),
    .grant   (grant),
    .done    (done),
    .done_id (done_id),
    .result  (result),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     cyc;
    int     id;
    longint prod;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];
  int   cyc          = 0;
  int   idle_from    = 0;
  int   m_ptr        = R - 1;
  int   rst_epoch    = 0;
  int   drv_timeouts = 0;
  bit   mon_en       = 1'b0;
  bit   end_req      = 1'b0;
  int   n_cmp        = 0;
  int   n_bad        = 0;

  function automatic int pick(input int p, input logic [R-1:0] r);
    for (int k = 1; k <= R; k++) begin
      if (r[(p + k) % R]) return (p + k) % R;
    end
    return -1;
  endfunction

  function automatic int msb_of(input int v);
    for (int i = N - 1; i >= 0; i--) if (((v >> i) & 1) != 0) return i;
    return -1;
  endfunction

  // Reference model: one multiply at a time, arbitration only while the unit is free.
  always @(posedge clk) begin
    if (rst) begin
      gq.delete();
      dq.delete();
      m_ptr     = R - 1;
      idle_from = cyc + 1;
      rst_epoch++;
    end else if (cyc >= idle_from && req != '0) begin
      int w, a, b, lat;
      w   = pick(m_ptr, req);
      a   = int'(op_a[w*N +: N]);
      b   = int'(op_b[w*N +: N]);
      lat = (b == 0) ? 1 : msb_of(b) + 2;
      gq.push_back('{cyc + 1, w, 0});
      dq.push_back('{cyc + 1 + lat, w, longint'(a) * longint'(b)});
      idle_from = cyc + 1 + lat + 1;
      m_ptr     = w;
    end
    cyc++;
  end

  task automatic check(input string name, input longint act, input longint req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, req_v);
    end
  endtask

  // Monitor: samples just after each edge, pops the scoreboard and compares.
  always @(posedge clk) begin
    longint      hold_res;
    int          hold_id;
    int          seen_epoch;
    logic [R-1:0] exp_g, exp_d;
    #1;
    if (seen_epoch != rst_epoch) begin
      hold_res   = 0;
      hold_id    = 0;
      seen_epoch = rst_epoch;
    end
    if (mon_en) begin
      exp_g = '0;
      exp_d = '0;
      while (gq.size() > 0 && gq[0].cyc < cyc) void'(gq.pop_front());
      while (dq.size() > 0 && dq[0].cyc < cyc) void'(dq.pop_front());
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        exp_g[gq[0].id] = 1'b1;
        void'(gq.pop_front());
      end
      if (dq.size() > 0 && dq[0].cyc == cyc) begin
        exp_d[dq[0].id] = 1'b1;
        hold_res        = dq[0].prod;
        hold_id         = dq[0].id;
        void'(dq.pop_front());
      end
      check("grant",   longint'(grant),   longint'(exp_g));
      check("done",    longint'(done),    longint'(exp_d));
      check("done_id", longint'(done_id), longint'(hold_id));
      check("result",  longint'(result),  hold_res);
      check("busy",    longint'(busy),    longint'(cyc < idle_from));
    end
    if (end_req) begin
      check("timeouts",      longint'(drv_timeouts), 0);
      check("pending_grant", longint'(gq.size()),    0);
      check("pending_done",  longint'(dq.size()),    0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  task automatic set_req(input int i, input int a, input int b);
    req[i]         = 1'b1;
    op_a[i*N +: N] = N'(a);
    op_b[i*N +: N] = N'(b);
  endtask

  task automatic hold_for_grants(input int n);
    int got = 0;
    for (int t = 0; t < 200 && got < n; t++) begin
      @(negedge clk);
      if (grant != '0) got++;
    end
    if (got < n) begin
      drv_timeouts++;
      $display("FAIL grant_wait: saw %0d grants, expected %0d", got, n);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = (busy == 1'b0) && (gq.size() == 0) && (dq.size() == 0);
    end
    if (!ok) begin
      drv_timeouts++;
      $display("FAIL idle_wait: busy %0d, still expected after 200 cycles %0d", busy, 1'b0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [N-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return N'($urandom);
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Single request, then a zero multiplier.
    set_req(0, 6, 7);
    hold_for_grants(1); req = '0;
    wait_idle();
    set_req(1, 15, 0);
    hold_for_grants(1); req = '0;
    wait_idle();

    // Fairness with all requests held: 0,1,2,3,0.
    pulse_reset();
    set_req(0, 1, 1); set_req(1, 2, 3); set_req(2, 15, 15); set_req(3, 9, 11);
    hold_for_grants(5); req = '0;
    wait_idle();

    // Pointer wrap: after ptr=2, req=0101 picks 0 then 2.
    set_req(2, 5, 5);
    hold_for_grants(1); req = '0;
    wait_idle();
    set_req(0, 3, 14); set_req(2, 12, 13);
    hold_for_grants(2); req = '0;
    wait_idle();

    // Operands and req changed after capture are ignored.
    set_req(1, 13, 11);
    hold_for_grants(1);
    op_a[1*N +: N] = 4'd3;
    op_b[1*N +: N] = 4'd2;
    req[1] = 1'b0;
    wait_idle();

    // Reset mid-run, then requester 3 alone.
    set_req(2, 15, 15);
    hold_for_grants(1); req = '0;
    repeat (2) @(negedge clk);
    pulse_reset();
    set_req(3, 7, 9);
    hold_for_grants(1); req = '0;
    wait_idle();

    // Randomized traffic with occasional resets.
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        req = '0;
      end else begin
        for (int i = 0; i < R; i++) begin
          if (grant[i] || !req[i]) begin
            if ($urandom_range(0, 3) == 0) begin
              req[i]         = 1'b1;
              op_a[i*N +: N] = rand_op();
              op_b[i*N +: N] = rand_op();
            end else begin
              req[i] = 1'b0;
            end
          end
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    wait_idle();
    end_req = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_rr_scheduler.md
Name: mul_rr_scheduler

Overview:
- Shares one shift-add multiplier datapath between R requesters using a round-robin arbiter.
- Each requester presents operands with a level request. The scheduler grants one requester, latches its operands and runs the iterative multiply, then returns the product with a one-cycle done strobe addressed to that requester.
- Sits between the client blocks and the arithmetic core. Clients never drive the core directly.

Parameters:
- N, 4, operand width in bits; the product is 2N bits wide.
- R, 4, number of requesters; R >= 2. ID width IW = $clog2(R).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  R  level request per requester; held with its operands until that requester's grant bit pulses.
- op_a  in  R*N  multiplicands, packed; requester i uses bits [i*N +: N].
- op_b  in  R*N  multipliers, packed; same slicing as op_a.
- grant  out  R  one-hot, one-cycle pulse in the cycle the operands are captured.
- done  out  R  one-hot, one-cycle pulse when the result is valid for that requester.
- done_id  out  IW  index of the requester that owns result; updated with done.
- result  out  2N  product; holds until the next done.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - grant=0, done=0, done_id=0, result=0, busy=0.
  - state=IDLE; rr pointer ptr=R-1, so requester 0 has first priority.
  - Internal a_reg, b_reg and acc are cleared.
- Reset asserted mid-operation aborts the operation. No done is issued and ptr returns to R-1.
- States are IDLE, RUN and DONE.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner w = first set bit searching ptr+1, ptr+2, ... with wrap modulo R.
  - At the edge: grant<=onehot(w), a_reg<=zero-extended op_a[w] (2N bits), b_reg<=op_b[w], acc<=0, cur_id<=w, ptr<=w, state<=RUN.
- RUN:
  - grant is high only in the first RUN cycle.
  - If b_reg!=0: if b_reg[0]==1, acc<=acc+a_reg. Then b_reg<=b_reg>>1 and a_reg<=a_reg<<1.
  - If b_reg==0: result<=acc, done<=onehot(cur_id), done_id<=cur_id, state<=DONE.
- DONE lasts one cycle: done deasserts and state<=IDLE.
- Latency, with grant high in cycle c and m = index of the MSB of op_b:
  - op_b==0: done is high in cycle c+1.
  - Otherwise: done is high in cycle c+m+2.
  - The earliest next grant is 2 cycles after done.
- Arithmetic is unsigned. acc is 2N bits and cannot overflow. Max op_a times max op_b equals (2^N-1)^2 exactly.
- req and operand changes after grant are ignored until IDLE is re-entered.
- A req still high in IDLE is treated as a new request.
- The granted requester deasserting req mid-RUN has no effect.
- Requests arriving during RUN or DONE wait. Arbitration happens only in IDLE.
- Fairness: with all req bits permanently high, grants go 0,1,...,R-1,0,...
- Exactly one grant bit is high per arbitration, and at most one done bit is high at any time.

Decomposition:
- Package mul_sched_pkg holds the state enum (IDLE/RUN/DONE) and the IW computation helper.
- Sub-module mul_shift_add_core holds the a_reg/b_reg/acc iteration.
  - Interface: load, a, b, step_en, out finished flag (b_reg==0), acc.
  - The scheduler owns the FSM, round-robin pointer, grant/done and the result register.

Test Plan:
1. Reset, then req=0001, op_a[0]=6, op_b[0]=7 (N=4) -> grant=0001 next cycle; done=0001 with done_id=0, result=42 exactly 4 cycles after grant (m=2).
2. req=0010, op_b[1]=0, op_a[1]=15 -> result=0 with done=0010 one cycle after grant; busy drops the following cycle.
3. req=1111 held with distinct operands (1x1, 2x3, 15x15, 9x11) -> grant order 0,1,2,3,0. Results 1, 6, 225, 99 each arrive with matching done_id.
4. After ptr=2, req=0101 -> requester 0 is granted (wrap past 3). Next arbitration with req=0101 -> requester 2.
5. During RUN for requester 1, change op_a[1]/op_b[1] and drop req[1] -> result still equals the captured product, and no new grant is issued to requester 1.
6. rst pulsed mid-RUN for 15x15 -> no done; all outputs are 0 the cycle after reset. The next req=1000 grants requester 3, which ptr=R-1 makes the lowest priority.
